// File: rtl/hv_dac_frame_rx.sv
// Receiver/bus monitor for the 3-wire HV DAC serial link: decodes write frames into a
// shadow bank and promotes it on LOAD. Define HV_DAC_RX_FRAME_CNT_EN for ok_cnt/err_cnt.
module hv_dac_frame_rx #(
  parameter int NCH      = 8,
  parameter int DW       = 10,
  parameter int CMD_BASE = 2
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              ser_sclk,
  input  logic              ser_cs,
  input  logic              ser_din,
  input  logic              ser_load,
  input  logic [2:0]        rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic [NCH*DW-1:0] dac_vals,
  output logic              load_strb,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              err_sticky
`ifdef HV_DAC_RX_FRAME_CNT_EN
  ,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       err_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [2:0]             r_sclk, r_cs, r_din, r_load;
  state_t                 r_state;
  logic [4:0]             r_cnt;
  logic [15:0]            r_sr;
  logic [NCH-1:0][DW-1:0] r_shadow, r_active;

  logic                   w_sclk_fall, w_cs_fall, w_cs_rise, w_load_fall, w_take_bit;
  logic [3:0]             w_cmd;
  logic [DW-1:0]          w_data;
  logic [NCH-1:0]         w_hit;
  logic [DW-1:0]          w_rd;
  logic                   w_unused;

  // Sync chains reset low so a bus caught mid-frame (CS/LOAD low) yields no edge out of reset.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_sclk <= '0;
      r_cs   <= '0;
      r_din  <= '0;
      r_load <= '0;
    end else begin
      r_sclk <= {r_sclk[1:0], ser_sclk};
      r_cs   <= {r_cs[1:0],   ser_cs};
      r_din  <= {r_din[1:0],  ser_din};
      r_load <= {r_load[1:0], ser_load};
    end
  end

  assign w_sclk_fall = r_sclk[2] & ~r_sclk[1];
  assign w_cs_fall   = r_cs[2]   & ~r_cs[1];
  assign w_cs_rise   = ~r_cs[2]  &  r_cs[1];
  assign w_load_fall = r_load[2] & ~r_load[1];
  // A falling SCLK coincident with CS rising still belongs to the frame.
  assign w_take_bit  = w_sclk_fall & (~r_cs[1] | w_cs_rise);

  assign w_cmd    = r_sr[15:12];
  assign w_data   = r_sr[11 -: DW];
  assign w_unused = ^r_sr[1:0];
  assign dac_vals = r_active;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NCH; i++)
      w_hit[i] = (int'(w_cmd) == CMD_BASE + i);
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NCH; i++)
      if (int'(rd_addr) == i) w_rd = r_active[i];
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      rd_data    <= '0;
      load_strb  <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      load_strb <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rd_data   <= w_rd;
      // Takes the pre-write shadow when a CHECK write lands in the same cycle.
      if (w_load_fall) begin
        r_active  <= r_shadow;
        load_strb <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_sr  <= '0;
          if (w_cs_fall) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_take_bit) begin
            r_sr <= {r_sr[14:0], r_din[2]};
            if (r_cnt != 5'd31) r_cnt <= r_cnt + 5'd1;
          end
          if (w_cs_rise) r_state <= CHECK;
        end
        CHECK: begin
          r_state <= IDLE;
          if (r_cnt != 5'd16) begin
            frame_err  <= 1'b1;
            err_sticky <= 1'b1;
          end else if (|w_hit) begin
            for (int i = 0; i < NCH; i++)
              if (w_hit[i]) r_shadow[i] <= w_data;
            frame_ok <= 1'b1;
          end else if (w_cmd != 4'd0) begin
            frame_err  <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HV_DAC_RX_FRAME_CNT_EN
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (frame_ok  && ok_cnt  != 16'hFFFF) ok_cnt  <= ok_cnt  + 16'd1;
      if (frame_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hv_dac_frame_rx.sv
// Randomised bench for hv_dac_frame_rx against a frame-level model of the DAC register banks.
module tb_hv_dac_frame_rx;
  logic        clkin = 0, reset = 1, ser_sclk = 0, ser_cs = 1, ser_din = 0, ser_load = 1;
  logic [2:0]  rd_addr = 0;
  logic [9:0]  rd_data;
  logic [79:0] dac_vals;
  logic        load_strb, frame_ok, frame_err, err_sticky;

  hv_dac_frame_rx dut (
    .clkin(clkin), .reset(reset), .ser_sclk(ser_sclk), .ser_cs(ser_cs), .ser_din(ser_din),
    .ser_load(ser_load), .rd_addr(rd_addr), .rd_data(rd_data), .dac_vals(dac_vals),
    .load_strb(load_strb), .frame_ok(frame_ok), .frame_err(frame_err), .err_sticky(err_sticky)
  );

  always #5 clkin = ~clkin;

  int checks = 0, errors = 0;
  logic [9:0] sh_m[8], act_m[8];
  logic sticky_m = 0;
  int ok_exp = 0, err_exp = 0, ld_exp = 0, ok_seen = 0, err_seen = 0, ld_seen = 0;
  bit settled = 0;
  logic [2:0] rd_q = 0;
  logic prev_ok = 0, prev_err = 0, prev_ld = 0;

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [79:0] act_flat();
    logic [79:0] f;
    for (int n = 0; n < 8; n++) f[n*10 +: 10] = act_m[n];
    return f;
  endfunction

  // Model: a frame is a bit count plus the last 16 bits shifted in.
  task automatic model_frame(input logic [31:0] v, input int n);
    int cmd;
    if (n != 16) begin err_exp++; sticky_m = 1; return; end
    cmd = int'(v[15:12]);
    if (cmd >= 2 && cmd <= 9) begin sh_m[cmd-2] = v[11:2]; ok_exp++; end
    else if (cmd != 0) begin err_exp++; sticky_m = 1; end
  endtask

  task automatic model_load();
    for (int n = 0; n < 8; n++) act_m[n] = sh_m[n];
    ld_exp++;
  endtask

  task automatic model_reset();
    for (int n = 0; n < 8; n++) begin sh_m[n] = 0; act_m[n] = 0; end
    sticky_m = 0;
  endtask

  // Compare process: pulse accounting every cycle, bank/readback whenever the bus is quiet.
  initial begin
    forever begin
      @(negedge clkin);
      if (frame_ok)  begin ok_seen++;  chk("ok_pulse_width",   prev_ok,  0); end
      if (frame_err) begin err_seen++; chk("err_pulse_width",  prev_err, 0); end
      if (load_strb) begin ld_seen++;  chk("load_pulse_width", prev_ld,  0); end
      if (settled) begin
        chk("dac_vals", dac_vals, act_flat());
        chk("err_sticky", err_sticky, sticky_m);
        chk("rd_data", rd_data, act_m[rd_q]);
      end
      prev_ok = frame_ok; prev_err = frame_err; prev_ld = load_strb;
      rd_q = rd_addr;
    end
  end

  task automatic tick();
    @(posedge clkin); #2;
  endtask

  // Leaves CS low after the last bit; DIN changes with SCLK rising.
  task automatic send_bits(input logic [31:0] v, input int n, input int h);
    ser_cs = 0; repeat (h) tick();
    for (int i = n - 1; i >= 0; i--) begin
      ser_sclk = 1; ser_din = v[i]; repeat (h) tick();
      ser_sclk = 0; repeat (h) tick();
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n, input int h);
    send_bits(v, n, h);
    ser_cs = 1; repeat (8) tick();
    model_frame(v, n);
  endtask

  task automatic do_load(input int hold);
    ser_load = 0; repeat (hold) tick();
    ser_load = 1; repeat (4) tick();
    model_load();
  endtask

  task automatic gap(input int n);
    chk("ok_count", ok_seen, ok_exp);
    chk("err_count", err_seen, err_exp);
    chk("load_count", ld_seen, ld_exp);
    settled = 1;
    repeat (n) begin tick(); rd_addr = 3'($urandom_range(0, 7)); end
    settled = 0;
  endtask

  initial begin
    int r, h, len, ok0, tmp;
    logic [31:0] v;
    model_reset();
    repeat (3) tick();
    chk("rst_dac_vals", dac_vals, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_pulses", {frame_ok, frame_err, load_strb}, 0);
    reset = 0; repeat (4) tick();
    gap(4);

    // Single frame at 8x oversampling, with exact latencies.
    send_bits(32'h2A5C, 16, 4);
    ser_cs = 1; repeat (3) tick();
    chk("ok_latency_early", frame_ok, 0);
    tick();
    chk("ok_latency", frame_ok, 1);
    model_frame(32'h2A5C, 16);
    repeat (4) tick();
    chk("shadow_not_active", dac_vals, 0);
    ser_load = 0; repeat (2) tick();
    chk("load_latency_early", dac_vals[9:0], 0);
    tick();
    chk("load_latency", dac_vals[9:0], 10'h297);
    chk("load_strb", load_strb, 1);
    rd_addr = 0; tick();
    chk("rd_ch0", rd_data, 10'h297);
    repeat (8) tick();
    ser_load = 1; repeat (4) tick();
    model_load();
    gap(6);

    // Full update: config no-op then every channel.
    ok0 = ok_seen;
    frame(32'h00FF, 16, 2);
    for (int c = 0; c < 8; c++) frame({16'd0, 4'(c + 2), 10'(c + 1), 2'b00}, 16, 2);
    do_load(3);
    gap(4);
    chk("full_ok_pulses", ok_seen - ok0, 8);
    for (int c = 0; c < 8; c++) begin
      rd_addr = 3'(c); tick();
      chk("full_rd_ch", rd_data, 10'(c + 1));
    end

    // Short and long frames, then a bad command; none may touch the bank.
    frame(32'h0000_0FFF, 12, 3);
    chk("sticky_after_short", err_sticky, 1);
    frame(32'h000A_BCDE, 20, 2);
    gap(3);
    frame(32'h0000_F3FC, 16, 2);
    do_load(2);
    gap(4);
    chk("bad_cmd_bank", dac_vals[79:70], 10'd8);

    // LOAD edge lands in the same cycle as the CHECK write of cmd 5.
    frame({16'd0, 4'd5, 10'h155, 2'b00}, 16, 2);
    do_load(2);
    gap(3);
    v = {16'd0, 4'd5, 10'h2AA, 2'b01};
    send_bits(v, 16, 3);
    ser_cs = 1; tick();
    ser_load = 0; repeat (8) tick();
    ser_load = 1; repeat (4) tick();
    model_load();
    model_frame(v, 16);
    gap(4);
    chk("sim_ch3_active_old", dac_vals[39:30], 10'h155);
    do_load(2);
    gap(3);
    chk("sim_ch3_second_load", dac_vals[39:30], 10'h2AA);

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      h = $urandom_range(2, 4);
      v = $urandom;
      if (r < 5) v[15:12] = 4'($urandom_range(2, 9));
      else if (r == 5) v[15:12] = 4'd0;
      else if (r == 6) begin
        tmp = $urandom_range(0, 6);
        v[15:12] = (tmp == 0) ? 4'd1 : 4'(tmp + 9);
      end
      if (r == 7) begin
        len = $urandom_range(1, 23);
        if (len >= 16) len++;
        frame(v, len, h);
      end else if (r >= 8) do_load($urandom_range(1, 12));
      else frame(v, 16, h);
      gap(3);
    end

    // Reset in the middle of a frame.
    send_bits(32'h0000_4ABC, 8, 2);
    reset = 1; ser_sclk = 0;
    model_reset();
    repeat (2) tick();
    reset = 0; tick();
    ser_cs = 1; repeat (8) tick();
    chk("midrst_dac_vals", dac_vals, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_sticky", err_sticky, 0);
    gap(4);
    frame({16'd0, 4'd3, 10'h3C1, 2'b00}, 16, 2);
    do_load(2);
    gap(4);
    chk("midrst_next_frame", dac_vals[19:10], 10'h3C1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
